// File: rtl/ysyx_22041412_axi_arbiter_rr.sv
// N-master arbiter in front of a single AXI bridge: independent read and write
// channels, each granting one master at a time until the bridge reports completion.

module ysyx_22041412_axi_arbiter_rr_chan #(
    parameter int NUM_MASTERS = 3,
    parameter int PRIO_MODE   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   busy
);
    localparam int IW = $clog2(NUM_MASTERS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          ptr_q, ptr_d;

    logic [IW-1:0]          eff_ptr;
    logic [NUM_MASTERS-1:0] rot_req;
    logic [NUM_MASTERS-1:0] rot_win;
    logic [NUM_MASTERS-1:0] winner;
    logic                   found;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          next_ptr;

    // Rotate requests so the pointer sits at bit 0, take the lowest set bit,
    // then rotate the one-hot result back to master numbering.
    always_comb begin
        eff_ptr = (PRIO_MODE == 1) ? '0 : ptr_q;
        rot_req = NUM_MASTERS'({req, req} >> eff_ptr);
        rot_win = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && rot_req[k]) begin
                rot_win[k] = 1'b1;
                found      = 1'b1;
            end
        end
        winner = NUM_MASTERS'(({rot_win, rot_win} << eff_ptr) >> NUM_MASTERS);
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                grant_idx = IW'(i);
            end
        end
        next_ptr = (grant_idx == IW'(NUM_MASTERS - 1)) ? '0 : grant_idx + IW'(1);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);
endmodule

module ysyx_22041412_axi_arbiter_rr #(
    parameter int NUM_MASTERS = 3,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int PRIO_MODE   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_valid,
    input  logic [NUM_MASTERS-1:0]            m_wen,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*8-1:0]          m_size,
    input  logic [NUM_MASTERS*8-1:0]          m_len,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            rd_grant,
    output logic [NUM_MASTERS-1:0]            wr_grant,
    output logic                              r_valid_i,
    output logic [ADDR_WIDTH-1:0]             r_addr_i,
    output logic [7:0]                        r_size_i,
    output logic [7:0]                        r_len_i,
    input  logic                              r_ready_o,
    input  logic [DATA_WIDTH-1:0]             data_read_o,
    output logic                              w_valid_i,
    output logic [ADDR_WIDTH-1:0]             w_addr_i,
    output logic [DATA_WIDTH-1:0]             w_data_i,
    output logic [7:0]                        w_size_i,
    output logic [7:0]                        w_len_i,
    input  logic                              w_ready_o,
    output logic [1:0]                        dbg_busy_o
);
    // Handshake: a master holds m_valid (with stable fields) until it sees its
    // m_ready strobe; downstream *_valid_i stays up until the bridge's *_ready_o.
    logic [NUM_MASTERS-1:0] rreq;
    logic [NUM_MASTERS-1:0] wreq;
    logic                   rd_busy;
    logic                   wr_busy;

    // A master granted on one channel is masked from the other, so it never
    // holds two grants even if it flips m_wen while waiting.
    assign rreq = m_valid & ~m_wen & ~wr_grant;
    assign wreq = m_valid &  m_wen & ~rd_grant;

    ysyx_22041412_axi_arbiter_rr_chan #(
        .NUM_MASTERS (NUM_MASTERS),
        .PRIO_MODE   (PRIO_MODE)
    ) u_rd_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rreq),
        .done  (r_ready_o),
        .grant (rd_grant),
        .busy  (rd_busy)
    );

    ysyx_22041412_axi_arbiter_rr_chan #(
        .NUM_MASTERS (NUM_MASTERS),
        .PRIO_MODE   (PRIO_MODE)
    ) u_wr_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wreq),
        .done  (w_ready_o),
        .grant (wr_grant),
        .busy  (wr_busy)
    );

    assign dbg_busy_o = {wr_busy, rd_busy};
    assign m_ready    = (rd_grant & {NUM_MASTERS{r_ready_o}}) |
                        (wr_grant & {NUM_MASTERS{w_ready_o}});

    // Grants are one-hot or zero, so each field simply copies the granted slice.
    always_comb begin
        r_valid_i = 1'b0;
        r_addr_i  = '0;
        r_size_i  = '0;
        r_len_i   = '0;
        w_valid_i = 1'b0;
        w_addr_i  = '0;
        w_data_i  = '0;
        w_size_i  = '0;
        w_len_i   = '0;
        m_rdata   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (rd_grant[i]) begin
                r_valid_i = m_valid[i] & ~m_wen[i];
                r_addr_i  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_size_i  = m_size[i*8 +: 8];
                r_len_i   = m_len[i*8 +: 8];
                m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = data_read_o;
            end
            if (wr_grant[i]) begin
                w_valid_i = m_valid[i] & m_wen[i];
                w_addr_i  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_data_i  = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_size_i  = m_size[i*8 +: 8];
                w_len_i   = m_len[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22041412_axi_arbiter_rr.sv
// Bench for the AXI arbiter: one round-robin and one fixed-priority instance
// share stimulus and are compared against a transaction-level model.

module tb_ysyx_22041412_axi_arbiter_rr;
    localparam int N  = 3;
    localparam int DW = 64;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N-1:0]  m_valid, m_wen;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*8-1:0]  m_size, m_len;
    logic          r_ready_o, w_ready_o;
    logic [DW-1:0] data_read_o;

    logic [N-1:0]    a_m_ready, a_rd_grant, a_wr_grant;
    logic [N*DW-1:0] a_m_rdata;
    logic            a_r_valid, a_w_valid;
    logic [AW-1:0]   a_r_addr, a_w_addr;
    logic [DW-1:0]   a_w_data;
    logic [7:0]      a_r_size, a_r_len, a_w_size, a_w_len;
    logic [1:0]      a_dbg;

    logic [N-1:0]    b_m_ready, b_rd_grant, b_wr_grant;
    logic [N*DW-1:0] b_m_rdata;
    logic            b_r_valid, b_w_valid;
    logic [AW-1:0]   b_r_addr, b_w_addr;
    logic [DW-1:0]   b_w_data;
    logic [7:0]      b_r_size, b_r_len, b_w_size, b_w_len;
    logic [1:0]      b_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N-1:0] exp_q[$];

    ysyx_22041412_axi_arbiter_rr #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO_MODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_wen(m_wen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_len(m_len),
        .m_ready(a_m_ready), .m_rdata(a_m_rdata),
        .rd_grant(a_rd_grant), .wr_grant(a_wr_grant),
        .r_valid_i(a_r_valid), .r_addr_i(a_r_addr), .r_size_i(a_r_size), .r_len_i(a_r_len),
        .r_ready_o(r_ready_o), .data_read_o(data_read_o),
        .w_valid_i(a_w_valid), .w_addr_i(a_w_addr), .w_data_i(a_w_data),
        .w_size_i(a_w_size), .w_len_i(a_w_len), .w_ready_o(w_ready_o),
        .dbg_busy_o(a_dbg)
    );

    ysyx_22041412_axi_arbiter_rr #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO_MODE(1)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_wen(m_wen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_len(m_len),
        .m_ready(b_m_ready), .m_rdata(b_m_rdata),
        .rd_grant(b_rd_grant), .wr_grant(b_wr_grant),
        .r_valid_i(b_r_valid), .r_addr_i(b_r_addr), .r_size_i(b_r_size), .r_len_i(b_r_len),
        .r_ready_o(r_ready_o), .data_read_o(data_read_o),
        .w_valid_i(b_w_valid), .w_addr_i(b_w_addr), .w_data_i(b_w_data),
        .w_size_i(b_w_size), .w_len_i(b_w_len), .w_ready_o(w_ready_o),
        .dbg_busy_o(b_dbg)
    );

    // Reference model: per instance d (0 = round-robin, 1 = fixed) and channel
    // c (0 = read, 1 = write): is a transfer open, who owns it, who is favoured next.
    bit mb[2][2];
    int mo[2][2];
    int mp[2][2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                mb[d][c] = 1'b0;
                mo[d][c] = 0;
                mp[d][c] = 0;
            end
    endtask

    function automatic logic [N-1:0] chan_req(int d, int c);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = m_valid[i] && (m_wen[i] == (c == 1)) && !(mb[d][1-c] && mo[d][1-c] == i);
        return r;
    endfunction

    // Round-robin: the requester closest at or after the favoured index wins.
    function automatic int choose(int d, logic [N-1:0] rq, int ptr);
        int best = -1;
        int best_dist = N;
        for (int i = 0; i < N; i++) begin
            if (rq[i]) begin
                if (d == 1) begin
                    if (best < 0) best = i;
                end else if ((i - ptr + N) % N < best_dist) begin
                    best_dist = (i - ptr + N) % N;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] exp_grant(int d, int c);
        logic [N-1:0] g = '0;
        if (mb[d][c]) g[mo[d][c]] = 1'b1;
        return g;
    endfunction

    function automatic logic exp_valid(int d, int c);
        if (!mb[d][c]) return 1'b0;
        return m_valid[mo[d][c]] && (m_wen[mo[d][c]] == (c == 1));
    endfunction

    function automatic logic [N-1:0] exp_ready(int d);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            r[i] = (mb[d][0] && mo[d][0] == i && r_ready_o) || (mb[d][1] && mo[d][1] == i && w_ready_o);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_rdata(int d);
        logic [N*DW-1:0] r = '0;
        if (mb[d][0]) r[mo[d][0]*DW +: DW] = data_read_o;
        return r;
    endfunction

    function automatic logic [AW+15:0] exp_rf(int d);
        int o = mo[d][0];
        if (!mb[d][0]) return '0;
        return {m_addr[o*AW +: AW], m_size[o*8 +: 8], m_len[o*8 +: 8]};
    endfunction

    function automatic logic [AW+DW+15:0] exp_wf(int d);
        int o = mo[d][1];
        if (!mb[d][1]) return '0;
        return {m_addr[o*AW +: AW], m_wdata[o*DW +: DW], m_size[o*8 +: 8], m_len[o*8 +: 8]};
    endfunction

    // Advance the model with the inputs present at the coming edge, then the clock.
    task automatic tick();
        bit nb[2][2];
        int no[2][2];
        int np[2][2];
        logic [N-1:0] rq;
        logic done;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                nb[d][c] = mb[d][c];
                no[d][c] = mo[d][c];
                np[d][c] = mp[d][c];
                if (rst_n) begin
                    done = (c == 0) ? r_ready_o : w_ready_o;
                    if (!mb[d][c]) begin
                        rq = chan_req(d, c);
                        if (rq != '0) begin
                            nb[d][c] = 1'b1;
                            no[d][c] = choose(d, rq, mp[d][c]);
                        end
                    end else if (done) begin
                        nb[d][c] = 1'b0;
                        np[d][c] = (mo[d][c] + 1) % N;
                    end
                end
            end
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                mb[d][c] = nb[d][c];
                mo[d][c] = no[d][c];
                mp[d][c] = np[d][c];
            end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m_valid = '0;
        m_wen   = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_size  = '0;
        m_len   = '0;
    endtask

    task automatic set_master(int i, logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] wd);
        m_valid[i]         = v;
        m_wen[i]           = w;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = wd;
        m_size[i*8 +: 8]   = 8'd3;
        m_len[i*8 +: 8]    = 8'd0;
    endtask

    task automatic do_reset();
        idle_all();
        r_ready_o = 1'b0;
        w_ready_o = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        m_valid = '1;
        m_wen = 3'b010;
        m_addr = {3{32'h8000_0000}};
        m_wdata = '1;
        m_size = '1;
        m_len = '1;
        r_ready_o = 1'b1;
        w_ready_o = 1'b1;
        data_read_o = 64'hFFFF_0000_FFFF_0000;
        #12;
        n_cmp++;
        if ({a_m_ready, a_m_rdata, a_rd_grant, a_wr_grant, a_r_valid, a_r_addr, a_r_size, a_r_len,
             a_w_valid, a_w_addr, a_w_data, a_w_size, a_w_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grants rd=%b wr=%b ready=%b rv=%b wv=%b, want all 0",
                     a_rd_grant, a_wr_grant, a_m_ready, a_r_valid, a_w_valid);
        end
        idle_all();
        r_ready_o = 1'b0;
        w_ready_o = 1'b0;
        data_read_o = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            n_cmp++;
            if ({a_rd_grant, a_wr_grant, a_r_valid, a_w_valid, a_m_ready, b_rd_grant, b_wr_grant} !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs cyc %0d: rd=%b wr=%b rv=%b wv=%b rdy=%b, want 0",
                         cyc, a_rd_grant, a_wr_grant, a_r_valid, a_w_valid, a_m_ready);
            end
            tick();
        end
    endtask

    task automatic test_single_read();
        do_reset();
        set_master(1, 1'b1, 1'b0, 32'h8000_0000, '0);
        #1;
        n_cmp++;
        if (a_rd_grant !== 3'b000) begin
            n_fail++;
            $display("FAIL single_c0_grant: got %b want 000", a_rd_grant);
        end
        tick();
        n_cmp++;
        if (a_rd_grant !== 3'b010 || a_r_valid !== 1'b1 || a_r_addr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL single_c1: grant=%b rv=%b addr=%h want 010 1 80000000", a_rd_grant, a_r_valid, a_r_addr);
        end
        for (int c = 2; c < 4; c++) begin
            tick();
            n_cmp++;
            if (a_rd_grant !== 3'b010 || a_m_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL single_hold c%0d: grant=%b ready=%b want 010 000", c, a_rd_grant, a_m_ready);
            end
        end
        tick();
        r_ready_o = 1'b1;
        data_read_o = 64'h0000_0000_DEAD_BEEF;
        #1;
        n_cmp++;
        if (a_m_ready !== 3'b010 || a_m_rdata[DW +: DW] !== 64'h0000_0000_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_c4: ready=%b rdata1=%h want 010 deadbeef", a_m_ready, a_m_rdata[DW +: DW]);
        end
        tick();
        m_valid[1] = 1'b0;
        r_ready_o = 1'b0;
        #1;
        n_cmp++;
        if (a_rd_grant !== 3'b000 || a_r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c5: grant=%b rv=%b want 000 0", a_rd_grant, a_r_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < N; i++) set_master(i, 1'b1, 1'b0, 32'h1000_0000 + 32'(i * 16), '0);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(3'b001);
            exp_q.push_back(3'b010);
            exp_q.push_back(3'b100);
        end
        #1;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tick();
            n_cmp++;
            if (a_rd_grant !== want) begin
                n_fail++;
                $display("FAIL rr_order: got %b want %b", a_rd_grant, want);
            end
            tick();
            r_ready_o = 1'b1;
            #1;
            n_cmp++;
            if (a_m_ready !== want) begin
                n_fail++;
                $display("FAIL rr_ready: got %b want %b", a_m_ready, want);
            end
            tick();
            r_ready_o = 1'b0;
            #1;
            n_cmp++;
            if (a_rd_grant !== 3'b000) begin
                n_fail++;
                $display("FAIL rr_gap: got %b want 000", a_rd_grant);
            end
        end
        idle_all();
        #1;
        tick();
    endtask

    task automatic test_fixed_priority();
        set_master(0, 1'b1, 1'b0, 32'h2000_0000, '0);
        set_master(2, 1'b1, 1'b0, 32'h2000_0200, '0);
        #1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (b_rd_grant !== 3'b001) begin
                n_fail++;
                $display("FAIL fp_grant round %0d: got %b want 001", k, b_rd_grant);
            end
            n_cmp++;
            if (a_rd_grant !== exp_grant(0, 0)) begin
                n_fail++;
                $display("FAIL fp_rr_grant round %0d: got %b want %b", k, a_rd_grant, exp_grant(0, 0));
            end
            r_ready_o = 1'b1;
            #1;
            tick();
            r_ready_o = 1'b0;
            #1;
        end
        idle_all();
        #1;
        tick();
    endtask

    task automatic test_concurrent();
        set_master(0, 1'b1, 1'b0, 32'h8000_0040, '0);
        set_master(1, 1'b1, 1'b1, 32'h8000_0100, 64'h1234);
        #1;
        tick();
        n_cmp++;
        if (a_r_valid !== 1'b1 || a_w_valid !== 1'b1 || a_w_data !== 64'h1234 || a_w_addr !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL conc_c1: rv=%b wv=%b wdata=%h waddr=%h want 1 1 1234 80000100",
                     a_r_valid, a_w_valid, a_w_data, a_w_addr);
        end
        n_cmp++;
        if (a_rd_grant !== 3'b001 || a_wr_grant !== 3'b010) begin
            n_fail++;
            $display("FAIL conc_grants: rd=%b wr=%b want 001 010", a_rd_grant, a_wr_grant);
        end
        w_ready_o = 1'b1;
        #1;
        n_cmp++;
        if (a_m_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL conc_wready: got %b want 010", a_m_ready);
        end
        tick();
        m_valid[1] = 1'b0;
        w_ready_o = 1'b0;
        #1;
        n_cmp++;
        if (a_wr_grant !== 3'b000 || a_rd_grant !== 3'b001 || a_w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL conc_wdone: wr=%b rd=%b wv=%b want 000 001 0", a_wr_grant, a_rd_grant, a_w_valid);
        end
        r_ready_o = 1'b1;
        data_read_o = 64'hCAFE_0000_0000_0001;
        #1;
        n_cmp++;
        if (a_m_ready !== 3'b001 || a_m_rdata[0 +: DW] !== 64'hCAFE_0000_0000_0001) begin
            n_fail++;
            $display("FAIL conc_rready: ready=%b rdata0=%h want 001 cafe000000000001", a_m_ready, a_m_rdata[0 +: DW]);
        end
        tick();
        m_valid[0] = 1'b0;
        r_ready_o = 1'b0;
        #1;
        n_cmp++;
        if (a_rd_grant !== 3'b000 || a_wr_grant !== 3'b000) begin
            n_fail++;
            $display("FAIL conc_end: rd=%b wr=%b want 000 000", a_rd_grant, a_wr_grant);
        end
    endtask

    task automatic test_async_reset();
        set_master(0, 1'b1, 1'b1, 32'h8000_0200, 64'h55);
        #1;
        tick();
        n_cmp++;
        if (a_wr_grant !== 3'b001 || a_w_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: wr=%b wv=%b want 001 1", a_wr_grant, a_w_valid);
        end
        #2;
        rst_n = 1'b0;
        w_ready_o = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (a_w_valid !== 1'b0 || a_wr_grant !== 3'b000 || a_m_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_abort: wv=%b wr=%b ready=%b want 0 000 000", a_w_valid, a_wr_grant, a_m_ready);
        end
        w_ready_o = 1'b0;
        set_master(2, 1'b1, 1'b1, 32'h8000_0300, 64'h77);
        #2;
        rst_n = 1'b1;
        #1;
        tick();
        n_cmp++;
        if (a_wr_grant !== 3'b001 || a_wr_grant !== exp_grant(0, 1)) begin
            n_fail++;
            $display("FAIL areset_first: got %b want 001", a_wr_grant);
        end
        idle_all();
        w_ready_o = 1'b1;
        #1;
        tick();
        w_ready_o = 1'b0;
        #1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) m_valid[i] = ~m_valid[i];
                if ($urandom_range(0, 7) == 0) m_wen[i] = ~m_wen[i];
                m_addr[i*AW +: AW]  = $urandom;
                m_wdata[i*DW +: DW] = {$urandom, $urandom};
                m_size[i*8 +: 8]    = 8'($urandom_range(0, 255));
                m_len[i*8 +: 8]     = 8'($urandom_range(0, 255));
            end
            r_ready_o   = ($urandom_range(0, 2) == 0);
            w_ready_o   = ($urandom_range(0, 2) == 0);
            data_read_o = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (a_rd_grant !== exp_grant(0, 0) || a_wr_grant !== exp_grant(0, 1)) begin
                n_fail++;
                $display("FAIL rnd_grant cyc %0d: rd=%b wr=%b want %b %b", cyc, a_rd_grant, a_wr_grant,
                         exp_grant(0, 0), exp_grant(0, 1));
            end
            n_cmp++;
            if (a_r_valid !== exp_valid(0, 0) || a_w_valid !== exp_valid(0, 1)) begin
                n_fail++;
                $display("FAIL rnd_valid cyc %0d: rv=%b wv=%b want %b %b", cyc, a_r_valid, a_w_valid,
                         exp_valid(0, 0), exp_valid(0, 1));
            end
            n_cmp++;
            if ({a_r_addr, a_r_size, a_r_len} !== exp_rf(0)) begin
                n_fail++;
                $display("FAIL rnd_rfields cyc %0d: got %h want %h", cyc, {a_r_addr, a_r_size, a_r_len}, exp_rf(0));
            end
            n_cmp++;
            if ({a_w_addr, a_w_data, a_w_size, a_w_len} !== exp_wf(0)) begin
                n_fail++;
                $display("FAIL rnd_wfields cyc %0d: got %h want %h", cyc,
                         {a_w_addr, a_w_data, a_w_size, a_w_len}, exp_wf(0));
            end
            n_cmp++;
            if (a_m_ready !== exp_ready(0) || a_m_rdata !== exp_rdata(0)) begin
                n_fail++;
                $display("FAIL rnd_return cyc %0d: ready=%b want %b", cyc, a_m_ready, exp_ready(0));
            end
            n_cmp++;
            if (a_dbg !== {mb[0][1], mb[0][0]}) begin
                n_fail++;
                $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, a_dbg, {mb[0][1], mb[0][0]});
            end
            n_cmp++;
            if (b_rd_grant !== exp_grant(1, 0) || b_wr_grant !== exp_grant(1, 1) || b_m_ready !== exp_ready(1)) begin
                n_fail++;
                $display("FAIL rnd_fp cyc %0d: rd=%b wr=%b rdy=%b want %b %b %b", cyc, b_rd_grant, b_wr_grant,
                         b_m_ready, exp_grant(1, 0), exp_grant(1, 1), exp_ready(1));
            end
            tick();
        end
        idle_all();
        r_ready_o = 1'b0;
        w_ready_o = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_concurrent();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
